// File: rtl/sha_bus_initiator.sv
// Transaction-bus master for the SHA accelerator: streams a 32-byte message in, issues HASH,
// collects the 32-byte digest and consumes the completion ack.
module sha_bus_initiator #(
  parameter int unsigned HASH_HOLD = 4,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] msg,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [255:0] digest,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  input  logic         ack_valid,
  input  logic [1:0]   ack_source_id,
  output logic         ack_ready,
  output logic [1:0]   opcode,
  output logic [1:0]   source_id,
  output logic [1:0]   dest_id,
  output logic         encdec,
  output logic [23:0]  addr
);

  localparam int unsigned HoldW = ($clog2(HASH_HOLD) > 3) ? $clog2(HASH_HOLD) : 3;
  localparam int unsigned TmrW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpWrRes = 2'b10;
  localparam logic [1:0] OpHash  = 2'b11;
  localparam logic [1:0] IdMem   = 2'b00;
  localparam logic [1:0] IdSha   = 2'b01;

  typedef enum logic [2:0] {StIdle, StLoad, StHash, StRead, StAck} state_e;

  state_e             state_q, state_d;
  logic [255:0]       shadow_q, shadow_d;
  logic [255:0]       capture_q, capture_d;
  logic [255:0]       digest_q, digest_d;
  logic [5:0]         byte_cnt_q, byte_cnt_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [TmrW-1:0]    tmr_q, tmr_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               timed_out;

  assign timed_out = (TIMEOUT != 0) && (tmr_q == TmrW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shadow_q   <= '0;
      capture_q  <= '0;
      digest_q   <= '0;
      byte_cnt_q <= '0;
      hold_q     <= '0;
      tmr_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      capture_q  <= capture_d;
      digest_q   <= digest_d;
      byte_cnt_q <= byte_cnt_d;
      hold_q     <= hold_d;
      tmr_q      <= tmr_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    capture_d  = capture_q;
    digest_d   = digest_q;
    byte_cnt_d = byte_cnt_q;
    hold_d     = hold_q;
    tmr_d      = tmr_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shadow_d   = msg;
          byte_cnt_d = '0;
          tmr_d      = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        tmr_d = tmr_q + TmrW'(1);
        if (timed_out) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else if (tx_ready) begin
          // Shadow shifts left so the outgoing byte is always the top byte.
          shadow_d   = {shadow_q[247:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 6'd1;
          tmr_d      = '0;
          if (byte_cnt_q == 6'd31) begin
            hold_d  = '0;
            state_d = StHash;
          end
        end
      end
      StHash: begin
        hold_d = hold_q + HoldW'(1);
        if (hold_q == HoldW'(HASH_HOLD - 1)) begin
          byte_cnt_d = '0;
          tmr_d      = '0;
          state_d    = StRead;
        end
      end
      StRead: begin
        tmr_d = tmr_q + TmrW'(1);
        if (timed_out) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else if (rx_valid) begin
          capture_d  = {capture_q[247:0], rx_data};
          byte_cnt_d = byte_cnt_q + 6'd1;
          tmr_d      = '0;
          if (byte_cnt_q == 6'd31) state_d = StAck;
        end
      end
      StAck: begin
        tmr_d = tmr_q + TmrW'(1);
        if (timed_out) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else if (ack_valid && ack_source_id == IdSha) begin
          digest_d = capture_q;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs decode purely from registered state.
  always_comb begin
    opcode    = 2'b00;
    source_id = IdMem;
    dest_id   = IdMem;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    rx_ready  = 1'b0;
    ack_ready = 1'b0;
    unique case (state_q)
      StLoad: begin
        opcode   = OpLoad;
        dest_id  = IdSha;
        tx_valid = 1'b1;
        tx_data  = shadow_q[255:248];
      end
      StHash: begin
        opcode  = OpHash;
        dest_id = IdSha;
      end
      StRead: begin
        opcode    = OpWrRes;
        source_id = IdSha;
        rx_ready  = 1'b1;
      end
      StAck:   ack_ready = 1'b1;
      default: ;
    endcase
  end

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign error  = error_q;
  assign digest = digest_q;
  assign encdec = 1'b0;
  assign addr   = 24'h000000;

endmodule

// File: tb/tb_sha_bus_initiator.sv
// Randomized bench for sha_bus_initiator: a cycle-level accelerator responder plus a job-level
// reference model (expected tx byte stream, digest, pulse counts, phase lengths).
module tb_sha_bus_initiator;

  localparam int unsigned HashHold = 4;
  localparam int unsigned Timeout  = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] msg;
  logic         busy, done, error;
  logic [255:0] digest;
  logic [7:0]   tx_data;
  logic         tx_valid, tx_ready;
  logic [7:0]   rx_data;
  logic         rx_valid, rx_ready;
  logic         ack_valid;
  logic [1:0]   ack_source_id;
  logic         ack_ready;
  logic [1:0]   opcode, source_id, dest_id;
  logic         encdec;
  logic [23:0]  addr;

  int n_cmp = 0;
  int n_mis = 0;
  logic [255:0] model_digest = '0;

  sha_bus_initiator #(
    .HASH_HOLD(HashHold),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .msg          (msg),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .digest       (digest),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .ack_valid    (ack_valid),
    .ack_source_id(ack_source_id),
    .ack_ready    (ack_ready),
    .opcode       (opcode),
    .source_id    (source_id),
    .dest_id      (dest_id),
    .encdec       (encdec),
    .addr         (addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // One complete job seen from the accelerator side. rst_after >= 0 resets the DUT once that
  // many digest bytes have been returned.
  task automatic run_job(input logic [255:0] m, input logic [255:0] d, input int tx_gap,
                         input int rx_gap, input int bad_acks, input logic [1:0] bad_id,
                         input bit stray, input bit no_ready, input int rst_after,
                         input bit poke_busy);
    logic [255:0] tx_vec = '0;
    int n_tx = 0, rx_idx = 0, acks = 0, busy_cyc = 0, hash_cyc = 0;
    int wait_tx = 0, wait_rx = 0, n_done = 0, n_err = 0;
    bit stray_sent = 0, ended = 0, aborted = 0;
    @(negedge clk);
    start = 1'b1;
    msg   = m;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      start     = 1'b0;
      msg       = '0;
      tx_ready  = 1'b0;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      ack_valid = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        n_done++;
        check("busy_at_done", busy, 1'b0);
      end
      if (error) n_err++;
      if (done || error) begin
        ended = 1;
        break;
      end
      if (poke_busy && cyc == 3) begin
        start = 1'b1;
        msg   = ~m;
      end
      if (opcode == 2'b11) begin
        hash_cyc++;
        check("hash_bus", {tx_valid, rx_ready, ack_ready, source_id, dest_id}, 7'b000_00_01);
        if (stray && !stray_sent) begin
          rx_valid   = 1'b1;
          rx_data    = 8'hEE;
          stray_sent = 1;
        end
      end
      if (tx_valid) begin
        if (!no_ready && (tx_gap == 0 || wait_tx >= tx_gap || $urandom_range(0, 1) == 1))
          tx_ready = 1'b1;
        if (tx_ready) begin
          check("load_bus", {opcode, source_id, dest_id}, 6'b01_00_01);
          if (n_tx < 32) tx_vec[255 - 8*n_tx -: 8] = tx_data;
          n_tx++;
          wait_tx = 0;
        end else begin
          wait_tx++;
        end
      end
      if (rx_ready && rx_idx < 32) begin
        if (rst_after >= 0 && rx_idx == rst_after) begin
          rst = 1'b1;
          #1;
          check("rst_bus_zero", {busy, done, error, tx_valid, rx_ready, ack_ready, opcode,
                                 source_id, dest_id, encdec, addr, tx_data}, '0);
          check("rst_digest_zero", digest, '0);
          start = 1'b1;
          msg   = rand256();
          @(negedge clk);
          start = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          @(negedge clk);
          check("start_in_rst_ignored", busy, 1'b0);
          model_digest = '0;
          aborted = 1;
          break;
        end
        if (wait_rx >= rx_gap) begin
          check("read_bus", {opcode, source_id, dest_id}, 6'b10_01_00);
          rx_valid = 1'b1;
          rx_data  = d[255 - 8*rx_idx -: 8];
          rx_idx++;
          wait_rx = 0;
        end else begin
          wait_rx++;
        end
      end
      if (ack_ready) begin
        check("ack_bus", {opcode, source_id, dest_id}, 6'b0);
        ack_valid     = 1'b1;
        ack_source_id = (acks < bad_acks) ? bad_id : 2'b01;
        acks++;
      end
    end
    tx_ready  = 1'b0;
    rx_valid  = 1'b0;
    ack_valid = 1'b0;
    if (!ended && !aborted) check("job_cycle_bound", 1'b0, 1'b1);
    if (ended && no_ready) begin
      check("timeout_error", n_err, 1);
      check("timeout_len", busy_cyc, Timeout + 1);
      check("timeout_no_tx", n_tx, 0);
      check("timeout_digest_kept", digest, model_digest);
    end else if (ended) begin
      model_digest = d;
      check("tx_count", n_tx, 32);
      check("tx_bytes", tx_vec, m);
      check("hash_len", hash_cyc, HashHold);
      check("rx_all_taken", rx_idx, 32);
      check("acks_to_done", acks, bad_acks + 1);
      check("done_count", n_done, 1);
      check("no_error", n_err, 0);
      check("digest", digest, model_digest);
    end
    if (ended) begin
      @(negedge clk);
      check("pulse_one_cycle", {done, error, busy}, 3'b000);
    end
  endtask

  initial begin
    logic [255:0] ma, da;
    rst = 1'b1;
    start = 1'b0;
    msg = '0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    ack_valid = 1'b0;
    ack_source_id = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, error, tx_valid, rx_ready, ack_ready, opcode,
                            source_id, dest_id, encdec, addr, tx_data}, '0);
    check("reset_digest", digest, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 32; i++) begin
      ma[255 - 8*i -: 8] = 8'(i);
      da[255 - 8*i -: 8] = 8'(8'hA0 + i);
    end
    run_job(ma, da, 0, 0, 0, 2'b00, 0, 0, -1, 0);
    check("digest_const", digest,
          256'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b7b8b9babbbcbdbebf);
    check("busy_after", busy, 1'b0);

    run_job(rand256(), rand256(), 3, 0, 0, 2'b00, 0, 0, -1, 1);  // tx_ready dithered
    run_job(rand256(), rand256(), 0, 2, 0, 2'b00, 1, 0, -1, 0);  // gapped rx + stray
    run_job(rand256(), rand256(), 0, 0, 5, 2'b00, 0, 0, -1, 0);  // wrong-source acks
    run_job(rand256(), rand256(), 0, 0, 0, 2'b00, 0, 1, -1, 0);  // never ready -> timeout
    run_job(rand256(), rand256(), 1, 0, 0, 2'b00, 0, 0, 10, 0);  // reset mid-READ
    run_job(rand256(), rand256(), 0, 0, 0, 2'b00, 0, 0, -1, 1);  // clean job after reset

    for (int j = 0; j < 4; j++) begin
      logic [1:0] bid;
      bid = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11);
      run_job(rand256(), rand256(), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), bid, 1'($urandom_range(0, 1)), 0, -1,
              1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
